axi4lite_regfile: RTL and testbench
===================================

AXI4LITE_REGFILE -- requirements
Module: axi4lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter NUM_REGS, default 4: number of implemented registers; 1 <= NUM_REGS <= 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter RESET_VALUE, default 0: DATA_WIDTH-bit reset value loaded into every register.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- s_axi_aclk  in  1  sole clock; all logic is rising-edge.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awvalid, s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte write enables.
- s_axi_wvalid, s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid, s_axi_bready  out/in  1  B handshake.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arvalid, s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid, s_axi_rready  out/in  1  R handshake.
- reg_q  out  NUM_REGS*DATA_WIDTH  flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle strobe per register written.

Function
REQ-006 SHALL compute register index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] and ignore the low byte-offset bits.
REQ-007 SHALL accept AW and W independently, each into its own one-entry holding stage; the AW and W channels may arrive in any order or in the same cycle.
REQ-008 SHALL drive s_axi_awready = 1 when the AW stage is empty and bvalid=0, and s_axi_wready = 1 when the W stage is empty and bvalid=0.
REQ-009 SHALL commit a write in the first cycle in which both stages are full: bytes with wstrb[k]=1 update, bytes with wstrb[k]=0 hold their value; then both stages clear and bvalid rises the next cycle.
REQ-010 SHALL, on commit with index >= NUM_REGS, leave all registers unchanged, keep wr_pulse at 0 and return bresp=2'b10 (SLVERR); in-range writes return 2'b00 (OKAY), including when wstrb=0.
REQ-011 SHALL hold bvalid and bresp stable until bready=1; bvalid clears on the cycle after that handshake, and a new commit may occur in the same cycle.
REQ-012 SHALL pulse wr_pulse[i] high for exactly the one cycle following an in-range commit to register i, including when wstrb=0.
REQ-013 SHALL drive s_axi_arready = !s_axi_rvalid; on an AR handshake it SHALL register rdata and rresp and assert rvalid the next cycle (1-cycle read latency).
REQ-014 SHALL return rdata=0 with rresp=2'b10 for a read with index >= NUM_REGS, and rresp=2'b00 otherwise.
REQ-015 SHALL hold rvalid, rdata and rresp stable until rready=1.
REQ-016 SHALL, when a read handshake and a write commit to the same register occur in the same cycle, return the pre-write value; the written value is visible to later reads.
REQ-017 SHALL process the read and write paths concurrently with no arbitration stall between them.
REQ-018 SHALL update reg_q in the cycle after commit, coincident with wr_pulse.

Reset
REQ-019 SHALL, while s_axi_aresetn=0 (asynchronous assert), force:
- every register to RESET_VALUE;
- both holding stages empty;
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0;
- awready=0, wready=0, arready=0.
REQ-020 SHALL drive awready, wready and arready to 1 in the first cycle after reset is released.
REQ-021 SHALL abandon any partially received write on reset mid-transaction, with no register modified.

Verification
(Configuration for all scenarios: DATA_WIDTH=32, ADDR_WIDTH=4, NUM_REGS=3.)
REQ-022 SHALL be verified with: AW addr=0x4 and W data=0xDEADBEEF, wstrb=0xF in the same cycle -> bresp=OKAY; wr_pulse=3'b010 for one cycle; reg 1 reads back 0xDEADBEEF.
REQ-023 SHALL be verified with: W data=0x11223344, wstrb=0x5 sent three cycles before AW addr=0x0, with reg 0 previously 0 -> reg 0 = 0x00220044; bvalid only after the AW handshake.
REQ-024 SHALL be verified with: write to addr=0xC and read from addr=0xC -> bresp=2'b10, rresp=2'b10, rdata=0; reg_q unchanged; wr_pulse=0.
REQ-025 SHALL be verified with: bready held low for 5 cycles after bvalid -> bvalid/bresp stable, and awready=wready=0 throughout; a second write is accepted only after the B handshake.
REQ-026 SHALL be verified with: reg 2=0xA5A5A5A5, then AR addr=0x8 in the same cycle as a commit of 0x5A5A5A5A to reg 2 -> rdata=0xA5A5A5A5; a following read returns 0x5A5A5A5A.
REQ-027 SHALL be verified with: aresetn asserted after the AW handshake of addr=0x0 but before W, RESET_VALUE=0x12345678 -> all of reg_q = 0x12345678; no bvalid; no wr_pulse.

Source files
------------

// File: rtl/axi4lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_regfile
// Purpose  : AXI4-Lite slave with NUM_REGS byte-strobed registers.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_regfile #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int C_STRB_W  = DATA_WIDTH / 8;
    localparam int C_IDX_LSB = $clog2(C_STRB_W);
    localparam int C_IDX_W   = ADDR_WIDTH - C_IDX_LSB;
    localparam logic [C_IDX_W:0] C_NUM_REGS_EXT = (C_IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    logic                  aw_full_q, aw_full_d;
    logic [C_IDX_W-1:0]    aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [C_STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic                  w_wr_in_range, w_rd_in_range;
    logic [C_IDX_W-1:0]    w_ar_idx;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    // Readies are gated by reset so they read 0 while reset is held.
    assign s_axi_awready = s_axi_aresetn && !aw_full_q && !bvalid_q;
    assign s_axi_wready  = s_axi_aresetn && !w_full_q  && !bvalid_q;
    assign s_axi_arready = s_axi_aresetn && !rvalid_q;

    assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_w_hs        = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_commit      = aw_full_q && w_full_q;
    assign w_wr_in_range = ({1'b0, aw_idx_q} < C_NUM_REGS_EXT);
    assign w_ar_idx      = s_axi_araddr[ADDR_WIDTH-1:C_IDX_LSB];
    assign w_rd_in_range = ({1'b0, w_ar_idx} < C_NUM_REGS_EXT);

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        if (w_commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_wr_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_in_range && (aw_idx_q == C_IDX_W'(i))) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int b = 0; b < C_STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Stages only accept while empty, so a handshake never collides with commit.
        if (w_aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:C_IDX_LSB];
        end
        if (w_w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == C_IDX_W'(i)) begin
                w_rd_mux = regs_q[i];
            end
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        // Reads sample regs_q, so a same-cycle commit returns the old value.
        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rd_mux;
            rresp_d  = w_rd_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign wr_pulse     = wr_pulse_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end

    if (C_IDX_LSB > 0) begin : g_addr_lsb
        logic w_unused_lsb;
        assign w_unused_lsb = ^{s_axi_awaddr[C_IDX_LSB-1:0], s_axi_araddr[C_IDX_LSB-1:0]};
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_regfile.sv
`default_nettype none
// Self-checking bench for axi4lite_regfile (32-bit data, 4-bit address, 3 registers).
module tb_axi4lite_regfile;

    localparam int          NR = 3;
    localparam logic [31:0] RV = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [95:0] reg_q;
    logic [2:0]  wr_pulse;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [NR];
    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];

    always #5 clk = ~clk;

    axi4lite_regfile #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR),
        .RESET_VALUE(RV)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .reg_q        (reg_q),
        .wr_pulse     (wr_pulse)
    );

    function automatic logic [95:0] model_flat();
        return {model[2], model[1], model[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && t < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout addr=%h: got aw_done=%0d w_done=%0d, required both 1", a, aw_done, w_done);
        end
        if (int'(a[3:2]) < NR) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic wait_b(output logic [1:0] r);
        int t = 0;
        while (!bvalid && t < 50) begin tick(); t++; end
        if (!bvalid) begin
            n_vec++; n_err++;
            $display("FAIL bvalid_timeout: got bvalid=0, required 1 within 50 cycles");
        end
        r = bvalid ? bresp : 2'bxx;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        int t = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 50) begin tick(); t++; end
        if (!rvalid) begin
            n_vec++; n_err++;
            $display("FAIL rvalid_timeout addr=%h: got rvalid=0, required 1", a);
        end
        d = rvalid ? rdata : 'x;
        r = rvalid ? rresp : 2'bxx;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic check_b(input string name);
        logic [1:0] r, e;
        wait_b(r);
        e = b_exp_q.pop_front();
        n_vec++;
        if (r !== e) begin n_err++; $display("FAIL %s_bresp: got %b required %b", name, r, e); end
    endtask

    task automatic check_r(input string name, input logic [3:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] e;
        do_read(a, d, r);
        e = r_exp_q.pop_front();
        n_vec++;
        if ({r, d} !== e) begin
            n_err++;
            $display("FAIL %s_read: got resp=%b data=%h required resp=%b data=%h", name, r, d, e[33:32], e[31:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        repeat (3) tick();
        n_vec++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_err++; $display("FAIL rst_readies: got %b required 000", {awready, wready, arready});
        end
        n_vec++;
        if ({bvalid, rvalid, wr_pulse} !== 5'b0) begin
            n_err++; $display("FAIL rst_valids: got b=%b r=%b pulse=%b required all 0", bvalid, rvalid, wr_pulse);
        end
        n_vec++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_err++; $display("FAIL rst_resp: got bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata);
        end
        n_vec++;
        if (reg_q !== {3{RV}}) begin
            n_err++; $display("FAIL rst_regs: got %h required %h", reg_q, {3{RV}});
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_err++; $display("FAIL post_rst_readies: got %b required 111", {awready, wready, arready});
        end
        for (int i = 0; i < NR; i++) model[i] = RV;
        tick();
    endtask

    task automatic test_write_same_cycle();
        b_exp_q.push_back(2'b00);
        do_write(4'h4, 32'hDEADBEEF, 4'hF);
        n_vec++;
        if (wr_pulse !== 3'b000) begin n_err++; $display("FAIL pulse_early: got %b required 000", wr_pulse); end
        tick();
        n_vec++;
        if (wr_pulse !== 3'b010) begin n_err++; $display("FAIL pulse_reg1: got %b required 010", wr_pulse); end
        n_vec++;
        if (reg_q[63:32] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL reg1_value: got %h required deadbeef", reg_q[63:32]);
        end
        check_b("same_cycle");
        n_vec++;
        if (wr_pulse !== 3'b000) begin n_err++; $display("FAIL pulse_one_cycle: got %b required 000", wr_pulse); end
        r_exp_q.push_back({2'b00, 32'hDEADBEEF});
        check_r("reg1", 4'h4);
    endtask

    task automatic test_w_before_aw();
        int t = 0;
        b_exp_q.push_back(2'b00);
        do_write(4'h0, 32'h0, 4'hF);
        check_b("zero_reg0");
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        while (!wready && t < 50) begin tick(); t++; end
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (bvalid !== 1'b0) begin n_err++; $display("FAIL w_only_bvalid cyc%0d: got %b required 0", k, bvalid); end
            tick();
        end
        awaddr = 4'h0; awvalid = 1'b1;
        n_vec++;
        if (awready !== 1'b1) begin n_err++; $display("FAIL late_awready: got %b required 1", awready); end
        tick();
        awvalid = 1'b0;
        n_vec++;
        if (bvalid !== 1'b0) begin n_err++; $display("FAIL early_bvalid: got %b required 0", bvalid); end
        model[0] = 32'h00220044;
        b_exp_q.push_back(2'b00);
        check_b("w_first");
        n_vec++;
        if (reg_q[31:0] !== 32'h00220044) begin
            n_err++; $display("FAIL strobe_merge: got %h required 00220044", reg_q[31:0]);
        end
        r_exp_q.push_back({2'b00, 32'h00220044});
        check_r("reg0_strb", 4'h0);
    endtask

    task automatic test_out_of_range();
        b_exp_q.push_back(2'b10);
        do_write(4'hC, 32'hCAFEF00D, 4'hF);
        tick();
        n_vec++;
        if (wr_pulse !== 3'b000) begin n_err++; $display("FAIL oob_pulse: got %b required 000", wr_pulse); end
        n_vec++;
        if (reg_q !== model_flat()) begin
            n_err++; $display("FAIL oob_regs: got %h required %h", reg_q, model_flat());
        end
        check_b("oob");
        r_exp_q.push_back({2'b10, 32'h0});
        check_r("oob", 4'hC);
    endtask

    task automatic test_back_pressure();
        int t = 0;
        b_exp_q.push_back(2'b00);
        do_write(4'h8, 32'h01234567, 4'hF);
        while (!bvalid && t < 50) begin tick(); t++; end
        awaddr = 4'h8; wdata = 32'h89ABCDEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                         k, bvalid, bresp, awready, wready);
            end
            tick();
        end
        check_b("bp_first");
        n_vec++;
        if (bvalid !== 1'b0) begin n_err++; $display("FAIL bp_bvalid_clear: got %b required 0", bvalid); end
        n_vec++;
        if (reg_q[95:64] !== 32'h01234567) begin
            n_err++; $display("FAIL bp_reg2_held: got %h required 01234567", reg_q[95:64]);
        end
        b_exp_q.push_back(2'b00);
        do_write(4'h8, 32'h89ABCDEF, 4'hF);
        check_b("bp_second");
        n_vec++;
        if (reg_q !== model_flat()) begin
            n_err++; $display("FAIL bp_regs: got %h required %h", reg_q, model_flat());
        end
    endtask

    task automatic test_read_during_write();
        b_exp_q.push_back(2'b00);
        do_write(4'h8, 32'hA5A5A5A5, 4'hF);
        check_b("raw_setup");
        n_vec++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_err++; $display("FAIL raw_readies: got %b required 111", {awready, wready, arready});
        end
        awaddr = 4'h8; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h8; arvalid = 1'b1;
        r_exp_q.push_back({2'b00, 32'hA5A5A5A5});
        b_exp_q.push_back(2'b00);
        tick();
        arvalid = 1'b0;
        n_vec++;
        if (wr_pulse !== 3'b100) begin n_err++; $display("FAIL raw_commit_pulse: got %b required 100", wr_pulse); end
        begin
            logic [33:0] e;
            e = r_exp_q.pop_front();
            n_vec++;
            if ({rvalid, rresp, rdata} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL raw_old_value: got rvalid=%b resp=%b data=%h required 1 %b %h",
                         rvalid, rresp, rdata, e[33:32], e[31:0]);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        model[2] = 32'h5A5A5A5A;
        check_b("raw_write");
        r_exp_q.push_back({2'b00, 32'h5A5A5A5A});
        check_r("raw_new", 4'h8);
    endtask

    task automatic test_reset_mid_write();
        awaddr = 4'h0; awvalid = 1'b1;
        n_vec++;
        if (awready !== 1'b1) begin n_err++; $display("FAIL mid_awready: got %b required 1", awready); end
        tick();
        awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) model[i] = RV;
        n_vec++;
        if ({reg_q, bvalid, wr_pulse, awready} !== {{3{RV}}, 5'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got regs=%h bvalid=%b pulse=%b awready=%b required %h 0 000 0",
                     reg_q, bvalid, wr_pulse, awready, {3{RV}});
        end
        tick();
        tick();
        rst_n = 1'b1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({bvalid, wr_pulse} !== 4'b0 || reg_q !== model_flat()) begin
                n_err++;
                $display("FAIL mid_abandon cyc%0d: got bvalid=%b pulse=%b regs=%h required 0 000 %h",
                         k, bvalid, wr_pulse, reg_q, model_flat());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_back_pressure();
        test_read_during_write();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
